// File: rtl/ptw_axi_read_bridge_pkg.sv
// Shared definitions for the page-table-walk AXI read bridge: FSM state
// encodings, fixed AXI attribute values and requester IDs.
package ptw_axi_read_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_RESP = 2'd3
    } ptw_state_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int ITLB_ID = 0;
    localparam int DTLB_ID = 1;

endpackage

// File: rtl/ptw_req_slot.sv
// One requester slot: a pending flag plus the 8-byte-aligned PTE address.
// A pulse while already pending is dropped so the first address wins; a
// pulse in the cycle the slot is being cleared starts a fresh request.
module ptw_req_slot #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  clear,
    output logic                  pending,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [ADDR_WIDTH-1:0] aligned_addr;

    // PTEs are 8 bytes, so the low three address bits are forced to zero.
    assign aligned_addr = req_addr & ~ADDR_WIDTH'(7);

    // Capture a new request, or release the slot once its data has returned.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending <= 1'b0;
            addr    <= '0;
        end else if (clear) begin
            pending <= req_valid;
            if (req_valid) addr <= aligned_addr;
        end else if (req_valid && !pending) begin
            pending <= 1'b1;
            addr    <= aligned_addr;
        end
    end

endmodule

// File: rtl/ptw_axi_read_bridge.sv
// Responder end of the ITLB/DTLB page-table-walk fetch path. Arbitrates the
// two requesters round-robin and issues one single-beat AXI4 read at a time,
// returning the PTE as a one-cycle pulse to whichever TLB asked for it.
module ptw_axi_read_bridge
    import ptw_axi_read_bridge_pkg::*;
#(
    parameter int         ADDR_WIDTH = 64,
    parameter int         DATA_WIDTH = 64,
    parameter int         ID_WIDTH   = 4,
    parameter logic [2:0] ARPROT_VAL = 3'b001
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
    output logic                  I_RESP_VALID,
    output logic [DATA_WIDTH-1:0] I_RESP_DATA,
    output logic                  I_RESP_ERR,
    input  logic                  D_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
    output logic                  D_RESP_VALID,
    output logic [DATA_WIDTH-1:0] D_RESP_DATA,
    output logic                  D_RESP_ERR,
    output logic                  M_ARVALID,
    input  logic                  M_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_ARADDR,
    output logic [ID_WIDTH-1:0]   M_ARID,
    output logic [7:0]            M_ARLEN,
    output logic [2:0]            M_ARSIZE,
    output logic [1:0]            M_ARBURST,
    output logic [2:0]            M_ARPROT,
    input  logic                  M_RVALID,
    output logic                  M_RREADY,
    input  logic [DATA_WIDTH-1:0] M_RDATA,
    input  logic [1:0]            M_RRESP,
    input  logic                  M_RLAST,
    input  logic [ID_WIDTH-1:0]   M_RID
);

    ptw_state_e state, state_next;

    logic                  i_pend, d_pend;
    logic [ADDR_WIDTH-1:0] i_addr, d_addr;
    logic                  i_clear, d_clear;

    logic grant_d;      // current grantee: 0 = ITLB, 1 = DTLB
    logic rr_pref_d;    // on a tie, prefer the DTLB
    logic contended;    // the current grant was decided by the tie-break
    logic grant_load;
    logic grant_sel;
    logic r_accept;
    logic resp_fire;
    logic rsp_err;

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_i_slot (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (I_REQ_VALID),
        .req_addr  (I_REQ_ADDR),
        .clear     (i_clear),
        .pending   (i_pend),
        .addr      (i_addr)
    );

    ptw_req_slot #(.ADDR_WIDTH(ADDR_WIDTH)) u_d_slot (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (D_REQ_VALID),
        .req_addr  (D_REQ_ADDR),
        .clear     (d_clear),
        .pending   (d_pend),
        .addr      (d_addr)
    );

    assign i_clear = r_accept && !grant_d;
    assign d_clear = r_accept &&  grant_d;

    assign M_ARLEN   = 8'd0;
    assign M_ARSIZE  = SIZE_8B;
    assign M_ARBURST = BURST_INCR;
    assign M_ARPROT  = ARPROT_VAL;

    assign I_RESP_VALID = resp_fire && !grant_d;
    assign D_RESP_VALID = resp_fire &&  grant_d;

    // Any non-OKAY response, a stray ID or a missing RLAST is an access fault.
    assign rsp_err = (M_RRESP != RESP_OKAY) || (M_RID != M_ARID) || !M_RLAST;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode and handshake strobes.
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        M_ARVALID  = 1'b0;
        M_RREADY   = 1'b0;
        grant_load = 1'b0;
        grant_sel  = 1'b0;
        r_accept   = 1'b0;
        resp_fire  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_pend || d_pend) begin
                    grant_load = 1'b1;
                    grant_sel  = (i_pend && d_pend) ? rr_pref_d : d_pend;
                    state_next = ST_AR;
                end
            end
            ST_AR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) state_next = ST_R;
            end
            ST_R: begin
                M_RREADY = 1'b1;
                if (M_RVALID) begin
                    r_accept   = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_fire  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, AR payload and round-robin pointer. The pointer only
    // moves after a contested grant, so back-to-back ties alternate.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_d   <= 1'b0;
            contended <= 1'b0;
            rr_pref_d <= 1'b0;
            M_ARADDR  <= '0;
            M_ARID    <= '0;
        end else begin
            if (grant_load) begin
                grant_d   <= grant_sel;
                contended <= i_pend && d_pend;
                M_ARADDR  <= grant_sel ? d_addr : i_addr;
                M_ARID    <= grant_sel ? ID_WIDTH'(DTLB_ID) : ID_WIDTH'(ITLB_ID);
            end
            if (resp_fire && contended) rr_pref_d <= !grant_d;
        end
    end

    // Response data/error per requester; held until that requester's next fetch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            I_RESP_DATA <= '0;
            I_RESP_ERR  <= 1'b0;
            D_RESP_DATA <= '0;
            D_RESP_ERR  <= 1'b0;
        end else if (r_accept) begin
            if (grant_d) begin
                D_RESP_DATA <= M_RDATA;
                D_RESP_ERR  <= rsp_err;
            end else begin
                I_RESP_DATA <= M_RDATA;
                I_RESP_ERR  <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_ptw_axi_read_bridge.sv
// Directed bench for ptw_axi_read_bridge: timing, arbitration, AR stall,
// error reporting, alignment, in-flight pulses and mid-transaction reset.
module tb_ptw_axi_read_bridge;

    logic        CLK = 1'b0;
    logic        RST;
    logic        I_REQ_VALID, D_REQ_VALID;
    logic [63:0] I_REQ_ADDR, D_REQ_ADDR;
    logic        I_RESP_VALID, D_RESP_VALID;
    logic [63:0] I_RESP_DATA, D_RESP_DATA;
    logic        I_RESP_ERR, D_RESP_ERR;
    logic        M_ARVALID, M_ARREADY;
    logic [63:0] M_ARADDR;
    logic [3:0]  M_ARID;
    logic [7:0]  M_ARLEN;
    logic [2:0]  M_ARSIZE;
    logic [1:0]  M_ARBURST;
    logic [2:0]  M_ARPROT;
    logic        M_RVALID, M_RREADY;
    logic [63:0] M_RDATA;
    logic [1:0]  M_RRESP;
    logic        M_RLAST;
    logic [3:0]  M_RID;

    int n_assert = 0;
    int n_fail   = 0;

    ptw_axi_read_bridge dut (
        .CLK(CLK), .RST(RST),
        .I_REQ_VALID(I_REQ_VALID), .I_REQ_ADDR(I_REQ_ADDR),
        .I_RESP_VALID(I_RESP_VALID), .I_RESP_DATA(I_RESP_DATA), .I_RESP_ERR(I_RESP_ERR),
        .D_REQ_VALID(D_REQ_VALID), .D_REQ_ADDR(D_REQ_ADDR),
        .D_RESP_VALID(D_RESP_VALID), .D_RESP_DATA(D_RESP_DATA), .D_RESP_ERR(D_RESP_ERR),
        .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
        .M_ARID(M_ARID), .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE),
        .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
        .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA),
        .M_RRESP(M_RRESP), .M_RLAST(M_RLAST), .M_RID(M_RID)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Plays the AXI slave for one fetch: waits for AR, optionally stalls
    // ARREADY (with a stray RVALID that must not be accepted), returns one R
    // beat and checks the response pulse. Optionally re-pulses the grantee in
    // the R handshake cycle.
    task automatic serve(input logic is_d, input logic [63:0] exp_addr,
                         input logic [63:0] rdata, input logic [1:0] rresp,
                         input logic [3:0] rid, input logic rlast,
                         input logic exp_err, input int ar_delay,
                         input logic repulse, input logic [63:0] repulse_addr);
        int t = 0;
        while (!M_ARVALID && t < 20) begin
            tick();
            t++;
        end
        check("arvalid_seen", 64'(M_ARVALID), 64'd1);
        check("araddr", M_ARADDR, exp_addr);
        check("arid", 64'(M_ARID), is_d ? 64'd1 : 64'd0);
        for (int i = 0; i < ar_delay; i++) begin
            M_RVALID = 1'b1;
            tick();
            check("stall_arvalid", 64'(M_ARVALID), 64'd1);
            check("stall_araddr", M_ARADDR, exp_addr);
            check("stall_arid", 64'(M_ARID), is_d ? 64'd1 : 64'd0);
            check("stall_rready", 64'(M_RREADY), 64'd0);
        end
        M_RVALID  = 1'b0;
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        check("r_rready", 64'(M_RREADY), 64'd1);
        check("r_arvalid", 64'(M_ARVALID), 64'd0);
        M_RVALID = 1'b1;
        M_RDATA  = rdata;
        M_RRESP  = rresp;
        M_RID    = rid;
        M_RLAST  = rlast;
        if (repulse) begin
            if (is_d) begin D_REQ_VALID = 1'b1; D_REQ_ADDR = repulse_addr; end
            else      begin I_REQ_VALID = 1'b1; I_REQ_ADDR = repulse_addr; end
        end
        tick();
        M_RVALID    = 1'b0;
        I_REQ_VALID = 1'b0;
        D_REQ_VALID = 1'b0;
        check("resp_valid_own", 64'(is_d ? D_RESP_VALID : I_RESP_VALID), 64'd1);
        check("resp_valid_other", 64'(is_d ? I_RESP_VALID : D_RESP_VALID), 64'd0);
        check("resp_data", is_d ? D_RESP_DATA : I_RESP_DATA, rdata);
        check("resp_err", 64'(is_d ? D_RESP_ERR : I_RESP_ERR), 64'(exp_err));
        tick();
        check("resp_pulse_end", 64'(is_d ? D_RESP_VALID : I_RESP_VALID), 64'd0);
        check("resp_data_hold", is_d ? D_RESP_DATA : I_RESP_DATA, rdata);
    endtask

    task automatic pulse(input logic do_i, input logic [63:0] ia,
                         input logic do_d, input logic [63:0] da);
        I_REQ_VALID = do_i; I_REQ_ADDR = ia;
        D_REQ_VALID = do_d; D_REQ_ADDR = da;
        tick();
        I_REQ_VALID = 1'b0;
        D_REQ_VALID = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        I_REQ_VALID = 1'b0; I_REQ_ADDR = '0;
        D_REQ_VALID = 1'b0; D_REQ_ADDR = '0;
        M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;
        M_RRESP = 2'b00; M_RLAST = 1'b1; M_RID = '0;
        tick(); tick(); tick();

        // Reset state and constant AR attributes.
        check("rst_arvalid", 64'(M_ARVALID), 64'd0);
        check("rst_rready", 64'(M_RREADY), 64'd0);
        check("rst_i_valid", 64'(I_RESP_VALID), 64'd0);
        check("rst_d_valid", 64'(D_RESP_VALID), 64'd0);
        check("rst_i_data", I_RESP_DATA, 64'd0);
        check("rst_araddr", M_ARADDR, 64'd0);
        check("arlen", 64'(M_ARLEN), 64'd0);
        check("arsize", 64'(M_ARSIZE), 64'd3);
        check("arburst", 64'(M_ARBURST), 64'd1);
        check("arprot", 64'(M_ARPROT), 64'd1);
        RST = 1'b0;
        tick();

        // Minimum latency: pulse cycle 0, ARVALID cycle 2, R cycle 3, RESP cycle 4.
        M_ARREADY = 1'b1; M_RVALID = 1'b1; M_RDATA = 64'h0000_0000_2000_04CF;
        M_RRESP = 2'b00; M_RID = 4'd0; M_RLAST = 1'b1;
        pulse(1'b1, 64'h0000_0000_8000_1238, 1'b0, 64'd0);
        check("lat_c1_arvalid", 64'(M_ARVALID), 64'd0);
        tick();
        check("lat_c2_arvalid", 64'(M_ARVALID), 64'd1);
        check("lat_c2_araddr", M_ARADDR, 64'h0000_0000_8000_1238);
        check("lat_c2_arid", 64'(M_ARID), 64'd0);
        check("lat_c2_rready", 64'(M_RREADY), 64'd0);
        tick();
        check("lat_c3_rready", 64'(M_RREADY), 64'd1);
        check("lat_c3_i_valid", 64'(I_RESP_VALID), 64'd0);
        tick();
        check("lat_c4_i_valid", 64'(I_RESP_VALID), 64'd1);
        check("lat_c4_i_data", I_RESP_DATA, 64'h0000_0000_2000_04CF);
        check("lat_c4_i_err", 64'(I_RESP_ERR), 64'd0);
        check("lat_c4_d_valid", 64'(D_RESP_VALID), 64'd0);
        M_ARREADY = 1'b0; M_RVALID = 1'b0;
        tick();
        check("lat_c5_i_valid", 64'(I_RESP_VALID), 64'd0);
        tick();

        // Tie: ITLB first, then DTLB; repeated tie goes to DTLB first.
        pulse(1'b1, 64'h1000, 1'b1, 64'h2000);
        serve(1'b0, 64'h1000, 64'h1111_0000_0000_0001, 2'b00, 4'd0, 1'b1, 1'b0, 0, 1'b0, 64'd0);
        serve(1'b1, 64'h2000, 64'h2222_0000_0000_0002, 2'b00, 4'd1, 1'b1, 1'b0, 0, 1'b0, 64'd0);
        pulse(1'b1, 64'h1000, 1'b1, 64'h2000);
        serve(1'b1, 64'h2000, 64'h3333_0000_0000_0003, 2'b00, 4'd1, 1'b1, 1'b0, 0, 1'b0, 64'd0);
        serve(1'b0, 64'h1000, 64'h4444_0000_0000_0004, 2'b00, 4'd0, 1'b1, 1'b0, 0, 1'b0, 64'd0);

        // ARREADY held low for 5 cycles with a stray RVALID.
        pulse(1'b1, 64'h0000_0000_0004_0040, 1'b0, 64'd0);
        serve(1'b0, 64'h0000_0000_0004_0040, 64'h5555_AAAA_5555_AAAA, 2'b00, 4'd0, 1'b1, 1'b0, 5, 1'b0, 64'd0);

        // DTLB error responses: SLVERR, then OKAY, then wrong RID, then no RLAST.
        pulse(1'b0, 64'd0, 1'b1, 64'h8000);
        serve(1'b1, 64'h8000, 64'hDEAD_BEEF_0000_0001, 2'b10, 4'd1, 1'b1, 1'b1, 0, 1'b0, 64'd0);
        pulse(1'b0, 64'd0, 1'b1, 64'h8008);
        serve(1'b1, 64'h8008, 64'hDEAD_BEEF_0000_0002, 2'b00, 4'd1, 1'b1, 1'b0, 0, 1'b0, 64'd0);
        pulse(1'b0, 64'd0, 1'b1, 64'h8010);
        serve(1'b1, 64'h8010, 64'hDEAD_BEEF_0000_0003, 2'b00, 4'd0, 1'b1, 1'b1, 0, 1'b0, 64'd0);
        pulse(1'b0, 64'd0, 1'b1, 64'h8018);
        serve(1'b1, 64'h8018, 64'hDEAD_BEEF_0000_0004, 2'b00, 4'd1, 1'b0, 1'b1, 0, 1'b0, 64'd0);

        // Unaligned address is aligned; second pulse while pending is ignored.
        pulse(1'b1, 64'h1005, 1'b0, 64'd0);
        pulse(1'b1, 64'h3000, 1'b0, 64'd0);
        serve(1'b0, 64'h1000, 64'h6666_0000_0000_0006, 2'b00, 4'd0, 1'b1, 1'b0, 0, 1'b0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("ignored_arvalid", 64'(M_ARVALID), 64'd0);
            check("ignored_i_valid", 64'(I_RESP_VALID), 64'd0);
            tick();
        end

        // Pulse in the cycle pending clears is captured as a new request.
        pulse(1'b0, 64'd0, 1'b1, 64'h9000);
        serve(1'b1, 64'h9000, 64'h7777_0000_0000_0007, 2'b00, 4'd1, 1'b1, 1'b0, 0, 1'b1, 64'hA00F);
        serve(1'b1, 64'hA008, 64'h8888_0000_0000_0008, 2'b00, 4'd1, 1'b1, 1'b0, 0, 1'b0, 64'd0);

        // Reset while in R drops the transaction.
        pulse(1'b1, 64'hB000, 1'b0, 64'd0);
        tick();
        check("rst_mid_arvalid", 64'(M_ARVALID), 64'd1);
        M_ARREADY = 1'b1;
        tick();
        M_ARREADY = 1'b0;
        check("rst_mid_in_r", 64'(M_RREADY), 64'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid_arvalid_after", 64'(M_ARVALID), 64'd0);
        check("rst_mid_rready_after", 64'(M_RREADY), 64'd0);
        check("rst_mid_data_cleared", I_RESP_DATA, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_mid_no_ar", 64'(M_ARVALID), 64'd0);
            check("rst_mid_no_resp", 64'(I_RESP_VALID), 64'd0);
        end
        pulse(1'b1, 64'hC000, 1'b0, 64'd0);
        serve(1'b0, 64'hC000, 64'h9999_0000_0000_0009, 2'b00, 4'd0, 1'b1, 1'b0, 0, 1'b0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
